// File: rtl/nes_pad_reader.sv
// ============================================================================
// Module   : nes_pad_reader
// Brief    : Polls an NES pad over latch/clock/data, decodes 8 buttons and
//            produces opposing-direction-filtered movement outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_pad_reader #(
  parameter int HALF_PERIOD = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_rate,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       button_up,
  output logic       button_down,
  output logic       button_left,
  output logic       button_right,
  output logic       valid,
  output logic       busy
);

  localparam int CW = $clog2(2 * HALF_PERIOD);
  localparam logic [CW-1:0] c_LAST_LATCH = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] c_LAST_HALF  = CW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      nes_latch    <= 1'b0;
      nes_clk      <= 1'b1;
      buttons      <= '0;
      button_up    <= 1'b0;
      button_down  <= 1'b0;
      button_left  <= 1'b0;
      button_right <= 1'b0;
      valid        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_rate) begin
            r_state   <= S_LATCH;
            r_cnt     <= '0;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LATCH: begin
          if (r_cnt == c_LAST_LATCH) begin
            r_state   <= S_LOW;
            r_cnt     <= '0;
            r_idx     <= '0;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOW: begin
          // Pad data is active-low; sample at the end of the low phase.
          if (r_cnt == c_LAST_HALF) begin
            r_shift[r_idx] <= ~nes_data;
            r_state        <= S_HIGH;
            r_cnt          <= '0;
            nes_clk        <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (r_cnt == c_LAST_HALF) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state      <= S_DONE;
              busy         <= 1'b0;
              valid        <= 1'b1;
              buttons      <= r_shift;
              button_up    <= r_shift[4] & ~r_shift[5];
              button_down  <= r_shift[5] & ~r_shift[4];
              button_left  <= r_shift[6] & ~r_shift[7];
              button_right <= r_shift[7] & ~r_shift[6];
            end else begin
              r_state <= S_LOW;
              r_idx   <= r_idx + 3'd1;
              nes_clk <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
// ============================================================================
// Module   : tb_nes_pad_reader
// Brief    : Self-checking bench; a behavioural pad model serves each DUT
//            (H=2 and H=1) and read timing/decoding is checked per read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nes_pad_reader;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      fr;
  logic [1:0][7:0] pad_vec;
  logic [1:0]      w_data;
  logic [1:0]      w_latch;
  logic [1:0]      w_nclk;
  logic [1:0][7:0] w_btn;
  logic [1:0][3:0] w_dir;   // {right, left, down, up}
  logic [1:0]      w_valid;
  logic [1:0]      w_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] sr = 8'h00;
    logic       prev_nclk = 1'b1;

    nes_pad_reader #(.HALF_PERIOD(g == 0 ? 2 : 1)) u_dut (
      .clk          (clk),
      .reset        (rst),
      .frame_rate   (fr[g]),
      .nes_data     (w_data[g]),
      .nes_latch    (w_latch[g]),
      .nes_clk      (w_nclk[g]),
      .buttons      (w_btn[g]),
      .button_up    (w_dir[g][0]),
      .button_down  (w_dir[g][1]),
      .button_left  (w_dir[g][2]),
      .button_right (w_dir[g][3]),
      .valid        (w_valid[g]),
      .busy         (w_busy[g])
    );

    // Pad: parallel-load while latched, shift on each rising shift clock.
    assign w_data[g] = ~sr[0];
    always @(negedge clk) begin
      if (w_latch[g])                sr <= pad_vec[g];
      else if (w_nclk[g] && !prev_nclk) sr <= {1'b0, sr[7:1]};
      prev_nclk <= w_nclk[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] exp_dirs(input logic [7:0] p);
    logic up, dn, lf, rt;
    up = p[4]; dn = p[5]; lf = p[6]; rt = p[7];
    if (p[4] && p[5]) begin up = 1'b0; dn = 1'b0; end
    if (p[6] && p[7]) begin lf = 1'b0; rt = 1'b0; end
    return {rt, lf, dn, up};
  endfunction

  // One poll of DUT g; extra_at (>0) re-pulses frame_rate in cycle t+extra_at.
  task automatic do_read(input int g, input logic [7:0] pad, input int extra_at, input string tag);
    int h, last;
    int lat_cnt, lat_first, lat_last, val_cnt, val_at, busy_cnt, busy_last;
    int low_pulses, low_cycles, early;
    logic prev_n;
    logic [7:0] btn0, btn_at;
    logic [3:0] dir_at;
    h = (g == 0) ? 2 : 1;
    last = 18 * h + 3;
    lat_cnt = 0; lat_first = 0; lat_last = 0; val_cnt = 0; val_at = 0;
    busy_cnt = 0; busy_last = 0; low_pulses = 0; low_cycles = 0; early = 0;
    btn_at = 8'h00; dir_at = 4'h0;
    @(negedge clk);
    pad_vec[g] = pad;
    fr[g] = 1'b1;
    btn0 = w_btn[g];
    prev_n = w_nclk[g];
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      fr[g] = (n == extra_at);
      if (w_latch[g]) begin
        lat_cnt++;
        if (lat_first == 0) lat_first = n;
        lat_last = n;
      end
      if (w_valid[g]) begin val_cnt++; val_at = n; end
      if (w_busy[g]) begin busy_cnt++; busy_last = n; end
      if (prev_n && !w_nclk[g]) low_pulses++;
      if (!w_nclk[g]) low_cycles++;
      prev_n = w_nclk[g];
      if (n <= 18 * h && w_btn[g] !== btn0) early = 1;
      if (n == 18 * h + 1) begin btn_at = w_btn[g]; dir_at = w_dir[g]; end
    end
    fr[g] = 1'b0;
    check({tag, "_latch_first"}, lat_first, 1);
    check({tag, "_latch_last"},  lat_last, 2 * h);
    check({tag, "_latch_cnt"},   lat_cnt, 2 * h);
    check({tag, "_valid_cnt"},   val_cnt, 1);
    check({tag, "_valid_at"},    val_at, 18 * h + 1);
    check({tag, "_busy_cnt"},    busy_cnt, 18 * h);
    check({tag, "_busy_last"},   busy_last, 18 * h);
    check({tag, "_low_pulses"},  low_pulses, 8);
    check({tag, "_low_cycles"},  low_cycles, 8 * h);
    check({tag, "_hold"},        early, 0);
    check({tag, "_buttons"},     btn_at, pad);
    check({tag, "_dirs"},        dir_at, exp_dirs(pad));
  endtask

  initial begin
    int vcnt, bcnt;
    rst = 1'b1;
    fr = 2'b00;
    pad_vec = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("reset_state%0d", g),
            {w_latch[g], w_nclk[g], w_busy[g], w_valid[g], w_btn[g], w_dir[g]},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0});

    // frame_rate coincident with reset is dropped
    fr = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    fr = 2'b00;
    @(negedge clk);
    check("fr_with_reset", {w_busy, w_latch}, 4'b0000);

    do_read(0, 8'h10, 0,  "up_only");
    do_read(0, 8'hB0, 0,  "up_down_right");
    do_read(0, 8'h00, 0,  "absent_pad");
    do_read(0, 8'h4C, 10, "refire_busy");
    do_read(0, 8'hC3, 37, "refire_done");
    check("refire_done_idle", w_busy[0], 1'b0);
    do_read(1, 8'hFF, 0,  "h1_all");
    for (int i = 0; i < 4; i++) begin
      do_read(0, 8'($urandom_range(0, 255)), 0, $sformatf("rnd_h2_%0d", i));
      do_read(1, 8'($urandom_range(0, 255)), 0, $sformatf("rnd_h1_%0d", i));
    end

    // Abort a read with reset at t+20; previous non-zero buttons must clear
    do_read(0, 8'h5A, 0, "pre_abort");
    @(negedge clk);
    pad_vec[0] = 8'hA5;
    fr[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      fr[0] = 1'b0;
      if (n == 20) rst = 1'b1;
    end
    @(negedge clk);
    check("abort_state",
          {w_latch[0], w_nclk[0], w_busy[0], w_valid[0], w_btn[0], w_dir[0]},
          {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
    rst = 1'b0;
    vcnt = 0; bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_valid[0]) vcnt++;
      if (w_busy[0] || w_latch[0] || w_btn[0] != 8'h00) bcnt++;
    end
    check("abort_no_valid", vcnt, 0);
    check("abort_quiet", bcnt, 0);
    do_read(0, 8'h96, 0, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
